// File: rtl/sisc_exec_ctrl_if.sv
// sisc_exec_ctrl_if
//   Bus between the SISC execute/control block and the surrounding datapath.
//   The datapath supplies the IR, PC, status and register-file reads. The
//   controller returns the ALU result, the flags, the branch target and every
//   select and write enable.
//
//   Modports
//     master : the controller (sisc_exec_ctrl)
//     slave  : the datapath (IR/PC/register file/status register/data memory)
//
//   Signals
//     ir[31:0]          instruction: op[31:28] mm[27:24] Rd[23:20] Rs[19:16]
//                       Rt[15:12] imm[15:0]
//     pc[15:0]          PC, already incremented after FETCH
//     stat[3:0]         status register {C,V,N,Z}
//     rsa/rsb[31:0]     register-file read ports A and B
//     alu_result[31:0]  ALU result
//     cc[3:0]           ALU flags {C,V,N,Z}
//     br_addr[15:0]     branch target
//     wb_sel[1:0]       writeback source select
//     mm_sel[1:0]       data-memory address select
//     stat_en, rf_we, rd_sel, mux5_sel, pc_rst, pc_write, pc_sel, ir_load,
//     dm_we             single-bit controls
interface sisc_exec_ctrl_if;
  logic [31:0] ir;
  logic [15:0] pc;
  logic [3:0]  stat;
  logic [31:0] rsa;
  logic [31:0] rsb;
  logic [31:0] alu_result;
  logic [3:0]  cc;
  logic        stat_en;
  logic [15:0] br_addr;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        rd_sel;
  logic        mux5_sel;
  logic        pc_rst;
  logic        pc_write;
  logic        pc_sel;
  logic        ir_load;
  logic        dm_we;
  logic [1:0]  mm_sel;

  modport master (
    input  ir, pc, stat, rsa, rsb,
    output alu_result, cc, stat_en, br_addr, rf_we, wb_sel, rd_sel,
           mux5_sel, pc_rst, pc_write, pc_sel, ir_load, dm_we, mm_sel
  );

  modport slave (
    output ir, pc, stat, rsa, rsb,
    input  alu_result, cc, stat_en, br_addr, rf_we, wb_sel, rd_sel,
           mux5_sel, pc_rst, pc_write, pc_sel, ir_load, dm_we, mm_sel
  );
endinterface

// File: rtl/sisc_exec_ctrl.sv
// sisc_exec_ctrl
//   Control/execute core of the SISC CPU. It contains the multicycle control
//   FSM, the 32-bit ALU and the branch-address unit. All datapath storage
//   (register file, PC, IR, memories, status register) lives outside.
//
//   Ports
//     clk    : system clock; all state changes happen on posedge
//     rst_f  : synchronous, active-low reset
//     bus    : sisc_exec_ctrl_if.master (datapath inputs, control outputs)
//
//   Configuration
//     SISC_EXEC_MUL_EN : when defined, ALU func 8 is MUL (low 32 bits of A*B).
//                        When undefined, func 8 yields 0 like other unused funcs.
module sisc_exec_ctrl (
  input  logic             clk,
  input  logic             rst_f,
  sisc_exec_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT
  } state_e;

  localparam logic [3:0] OP_ALUR = 4'd1;
  localparam logic [3:0] OP_ALUI = 4'd2;
  localparam logic [3:0] OP_MOV  = 4'd3;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_BNR  = 4'd7;
  localparam logic [3:0] OP_LOD  = 4'd8;
  localparam logic [3:0] OP_STR  = 4'd9;
  localparam logic [3:0] OP_HLT  = 4'd15;

  state_e      state_q;
  logic [3:0]  op;
  logic [3:0]  mm;
  logic [15:0] imm;
  logic [31:0] sextImm;
  logic [3:0]  aluFunc;
  logic [31:0] aluB;
  logic [32:0] sum33;
  logic [32:0] diff33;
  logic [31:0] res;
  logic        carry;
  logic        ovf;
  logic        brHit;
  logic        brTaken;
  logic        isMemOp;
  logic [7:0]  unusedIrFields;

  assign op             = bus.ir[31:28];
  assign mm             = bus.ir[27:24];
  assign imm            = bus.ir[15:0];
  assign sextImm        = {{16{imm[15]}}, imm};
  assign isMemOp        = (op == OP_LOD) || (op == OP_STR);
  // Register specifiers are decoded by the register file, not here.
  assign unusedIrFields = bus.ir[23:16];

  // Only ALU ops select a function; memory ops use ADD to form Rs+imm.
  assign aluFunc = ((op == OP_ALUR) || (op == OP_ALUI)) ? mm : 4'd0;
  assign aluB    = ((op == OP_ALUI) || isMemOp) ? sextImm : bus.rsb;
  assign sum33   = {1'b0, bus.rsa} + {1'b0, aluB};
  // Bit 32 of the 33-bit difference is the borrow (A < B unsigned).
  assign diff33  = {1'b0, bus.rsa} - {1'b0, aluB};

  // ALU result and carry/overflow
  always_comb begin
    res   = 32'd0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (aluFunc)
      4'd0: begin
        res   = sum33[31:0];
        carry = sum33[32];
        ovf   = (bus.rsa[31] == aluB[31]) && (sum33[31] != bus.rsa[31]);
      end
      4'd1: begin
        res   = diff33[31:0];
        carry = diff33[32];
        ovf   = (bus.rsa[31] != aluB[31]) && (diff33[31] != bus.rsa[31]);
      end
      4'd2: res = bus.rsa & aluB;
      4'd3: res = bus.rsa | aluB;
      4'd4: res = bus.rsa ^ aluB;
      4'd5: res = ~bus.rsa;
      4'd6: res = bus.rsa << aluB[4:0];
      4'd7: res = bus.rsa >> aluB[4:0];
`ifdef SISC_EXEC_MUL_EN
      4'd8: res = bus.rsa * aluB;
`else
      4'd8: res = 32'd0;
`endif
      default: res = 32'd0;
    endcase
  end

  assign bus.alu_result = res;
  assign bus.cc         = {carry, ovf, res[31], (res == 32'd0)};

  // mm is a flag mask: BRA/BRR take on any masked flag set, BNE/BNR on none.
  assign brHit = |(bus.stat & mm);
  always_comb begin
    brTaken = 1'b0;
    if ((op == OP_BRA) || (op == OP_BRR)) brTaken = brHit;
    if ((op == OP_BNE) || (op == OP_BNR)) brTaken = !brHit;
  end

  assign bus.br_addr = ((op == OP_BRR) || (op == OP_BNR)) ? (bus.pc + imm) : imm;

  // Control FSM; reset outranks every other transition.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_q <= START0;
    end else begin
      case (state_q)
        START0:    state_q <= START1;
        START1:    state_q <= FETCH;
        FETCH:     state_q <= DECODE;
        DECODE:    state_q <= (op == OP_HLT) ? HALT : EXECUTE;
        EXECUTE:   state_q <= MEM;
        MEM:       state_q <= WRITEBACK;
        WRITEBACK: state_q <= FETCH;
        HALT:      state_q <= HALT;
        default:   state_q <= START0;
      endcase
    end
  end

  // Control outputs decode from the current state and the held IR.
  always_comb begin
    bus.stat_en  = 1'b0;
    bus.rf_we    = 1'b0;
    bus.wb_sel   = 2'b00;
    bus.rd_sel   = 1'b0;
    bus.mux5_sel = 1'b0;
    bus.pc_rst   = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_sel   = 1'b0;
    bus.ir_load  = 1'b0;
    bus.dm_we    = 1'b0;
    bus.mm_sel   = 2'b00;
    case (state_q)
      START0: bus.pc_rst = 1'b1;
      FETCH: begin
        bus.ir_load  = 1'b1;
        bus.pc_write = 1'b1;
      end
      DECODE: begin
        if (brTaken) begin
          bus.pc_write = 1'b1;
          bus.pc_sel   = 1'b1;
        end
      end
      EXECUTE: begin
        if ((op == OP_ALUR) || (op == OP_ALUI)) bus.stat_en = 1'b1;
      end
      MEM: begin
        // mm[3] picks Rs+imm through the ALU instead of the raw immediate.
        if (isMemOp) bus.mm_sel = mm[3] ? 2'b00 : 2'b01;
        if (op == OP_STR) begin
          bus.rd_sel = 1'b1;
          bus.dm_we  = 1'b1;
        end
      end
      WRITEBACK: begin
        if ((op == OP_ALUR) || (op == OP_ALUI)) begin
          bus.rf_we  = 1'b1;
          bus.wb_sel = 2'b00;
        end else if (op == OP_LOD) begin
          bus.rf_we  = 1'b1;
          bus.wb_sel = 2'b01;
        end else if (op == OP_MOV) begin
          bus.rf_we  = 1'b1;
          bus.wb_sel = 2'b10;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// tb_sisc_exec_ctrl
//   Directed bench for sisc_exec_ctrl. The stimulus process drives one cycle
//   at a time and queues the hand-computed outputs for that cycle; a separate
//   monitor pops each queued entry at the falling edge and compares.
module tb_sisc_exec_ctrl;

  // Control vector order:
  // {stat_en, rf_we, wb_sel[1:0], rd_sel, mux5_sel, pc_rst, pc_write, pc_sel,
  //  ir_load, dm_we, mm_sel[1:0]}
  localparam logic [12:0] C_NONE    = 13'b0_0_00_0_0_0_0_0_0_0_00;
  localparam logic [12:0] C_START0  = 13'b0_0_00_0_0_1_0_0_0_0_00;
  localparam logic [12:0] C_FETCH   = 13'b0_0_00_0_0_0_1_0_1_0_00;
  localparam logic [12:0] C_BRTAKEN = 13'b0_0_00_0_0_0_1_1_0_0_00;
  localparam logic [12:0] C_EXALU   = 13'b1_0_00_0_0_0_0_0_0_0_00;
  localparam logic [12:0] C_WBALU   = 13'b0_1_00_0_0_0_0_0_0_0_00;
  localparam logic [12:0] C_WBLOD   = 13'b0_1_01_0_0_0_0_0_0_0_00;
  localparam logic [12:0] C_WBMOV   = 13'b0_1_10_0_0_0_0_0_0_0_00;
  localparam logic [12:0] C_MEMSTR  = 13'b0_0_00_1_0_0_0_0_0_1_01;
  localparam logic [12:0] C_MEMIMM  = 13'b0_0_00_0_0_0_0_0_0_0_01;

  typedef struct {
    string       name;
    logic [12:0] ctrl;
    bit          chkAlu;
    logic [31:0] alu;
    logic [3:0]  cc;
    bit          chkBr;
    logic [15:0] br;
  } exp_t;

  logic clk;
  logic rst_f;
  int   vectors;
  int   miscompares;
  exp_t expQ[$];
  exp_t cur;

  sisc_exec_ctrl_if bus ();

  sisc_exec_ctrl dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  logic [12:0] actCtrl;
  assign actCtrl = {bus.stat_en, bus.rf_we, bus.wb_sel, bus.rd_sel, bus.mux5_sel,
                    bus.pc_rst, bus.pc_write, bus.pc_sel, bus.ir_load, bus.dm_we,
                    bus.mm_sel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one queued expectation against the live outputs
  task automatic checkOutput(input exp_t e);
    bit bad;
    vectors++;
    bad = (actCtrl !== e.ctrl);
    if (e.chkAlu && ((bus.alu_result !== e.alu) || (bus.cc !== e.cc))) bad = 1'b1;
    if (e.chkBr && (bus.br_addr !== e.br)) bad = 1'b1;
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL %s: got ctrl=%b alu=%h cc=%b br=%h, expected ctrl=%b alu=%h cc=%b br=%h",
               e.name, actCtrl, bus.alu_result, bus.cc, bus.br_addr,
               e.ctrl, e.alu, e.cc, e.br);
    end
  endtask

  // Monitor: checks every expectation queued for the current cycle
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      cur = expQ.pop_front();
      checkOutput(cur);
    end
  end

  // Queues the expected outputs of the current cycle, then advances a clock
  task automatic applyStimulus(input string nm, input logic [12:0] c,
                               input bit ca, input logic [31:0] a, input logic [3:0] f,
                               input bit cb, input logic [15:0] b);
    exp_t e;
    e.name = nm; e.ctrl = c; e.chkAlu = ca; e.alu = a; e.cc = f; e.chkBr = cb; e.br = b;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction FETCH..WRITEBACK; ALU checked in EXECUTE, br_addr in DECODE
  task automatic runInstr(input string nm, input logic [31:0] irv,
                          input logic [12:0] dc, input logic [12:0] ec,
                          input logic [12:0] mc, input logic [12:0] wc,
                          input bit ca, input logic [31:0] a, input logic [3:0] f,
                          input bit cb, input logic [15:0] b);
    bus.ir = irv;
    applyStimulus({nm, ".fetch"}, C_FETCH, 1'b0, 32'd0, 4'd0, 1'b0, 16'd0);
    applyStimulus({nm, ".decode"}, dc, 1'b0, 32'd0, 4'd0, cb, b);
    applyStimulus({nm, ".execute"}, ec, ca, a, f, 1'b0, 16'd0);
    applyStimulus({nm, ".mem"}, mc, 1'b0, 32'd0, 4'd0, 1'b0, 16'd0);
    applyStimulus({nm, ".writeback"}, wc, 1'b0, 32'd0, 4'd0, 1'b0, 16'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_f    = 1'b0;
    bus.ir   = 32'd0;
    bus.pc   = 16'd0;
    bus.stat = 4'd0;
    bus.rsa  = 32'd0;
    bus.rsb  = 32'd0;
    @(posedge clk);
    #1;

    // Reset held for a second clock, then START0 -> START1 -> FETCH
    applyStimulus("resetHeld", C_START0, 1'b0, 32'd0, 4'd0, 1'b0, 16'd0);
    rst_f = 1'b1;
    applyStimulus("start0", C_START0, 1'b0, 32'd0, 4'd0, 1'b0, 16'd0);
    applyStimulus("start1", C_NONE, 1'b0, 32'd0, 4'd0, 1'b0, 16'd0);

    // ALU register ops
    bus.rsa = 32'd5; bus.rsb = 32'd7;
    runInstr("add", 32'h1031_2000, C_NONE, C_EXALU, C_NONE, C_WBALU,
             1'b1, 32'd12, 4'b0000, 1'b0, 16'd0);
    bus.rsa = 32'd1; bus.rsb = 32'd2;
    runInstr("sub", 32'h1131_2000, C_NONE, C_EXALU, C_NONE, C_WBALU,
             1'b1, 32'hFFFF_FFFF, 4'b1010, 1'b0, 16'd0);
    bus.rsa = 32'h7FFF_FFFF; bus.rsb = 32'd1;
    runInstr("addOvf", 32'h1031_2000, C_NONE, C_EXALU, C_NONE, C_WBALU,
             1'b1, 32'h8000_0000, 4'b0110, 1'b0, 16'd0);
    bus.rsa = 32'd1; bus.rsb = 32'd31;
    runInstr("shl31", 32'h1631_2000, C_NONE, C_EXALU, C_NONE, C_WBALU,
             1'b1, 32'h8000_0000, 4'b0010, 1'b0, 16'd0);
    bus.rsa = 32'h8000_0000; bus.rsb = 32'd36;
    runInstr("shr", 32'h1731_2000, C_NONE, C_EXALU, C_NONE, C_WBALU,
             1'b1, 32'h0800_0000, 4'b0000, 1'b0, 16'd0);
    bus.rsa = 32'h0000_A5A5; bus.rsb = 32'h0000_A5A5;
    runInstr("xorZero", 32'h1431_2000, C_NONE, C_EXALU, C_NONE, C_WBALU,
             1'b1, 32'd0, 4'b0001, 1'b0, 16'd0);
    bus.rsa = 32'd0;
    runInstr("notA", 32'h1531_2000, C_NONE, C_EXALU, C_NONE, C_WBALU,
             1'b1, 32'hFFFF_FFFF, 4'b0010, 1'b0, 16'd0);
    bus.rsa = 32'd3; bus.rsb = 32'd5;
`ifdef SISC_EXEC_MUL_EN
    runInstr("func8", 32'h1831_2000, C_NONE, C_EXALU, C_NONE, C_WBALU,
             1'b1, 32'd15, 4'b0000, 1'b0, 16'd0);
`else
    runInstr("func8", 32'h1831_2000, C_NONE, C_EXALU, C_NONE, C_WBALU,
             1'b1, 32'd0, 4'b0001, 1'b0, 16'd0);
`endif

    // ALU immediate: 1 + sext(0xFFFF) wraps to zero with carry out
    bus.rsa = 32'd1; bus.rsb = 32'hDEAD_BEEF;
    runInstr("addImm", 32'h2012_FFFF, C_NONE, C_EXALU, C_NONE, C_WBALU,
             1'b1, 32'd0, 4'b1001, 1'b0, 16'd0);

    runInstr("mov", 32'h3012_0000, C_NONE, C_NONE, C_NONE, C_WBMOV,
             1'b0, 32'd0, 4'd0, 1'b0, 16'd0);

    // Branches
    bus.pc = 16'h0011; bus.stat = 4'b0001;
    runInstr("brrNotTaken", 32'h5200_FFFE, C_NONE, C_NONE, C_NONE, C_NONE,
             1'b0, 32'd0, 4'd0, 1'b1, 16'h000F);
    bus.stat = 4'b0010;
    runInstr("brrTaken", 32'h5200_FFFE, C_BRTAKEN, C_NONE, C_NONE, C_NONE,
             1'b0, 32'd0, 4'd0, 1'b1, 16'h000F);
    bus.stat = 4'b1111;
    runInstr("braMask0", 32'h4000_1234, C_NONE, C_NONE, C_NONE, C_NONE,
             1'b0, 32'd0, 4'd0, 1'b1, 16'h1234);
    runInstr("bneMask0", 32'h6000_1234, C_BRTAKEN, C_NONE, C_NONE, C_NONE,
             1'b0, 32'd0, 4'd0, 1'b1, 16'h1234);
    bus.stat = 4'b0000;

    // Memory ops
    runInstr("strImm", 32'h9040_0008, C_NONE, C_NONE, C_MEMSTR, C_NONE,
             1'b0, 32'd0, 4'd0, 1'b0, 16'd0);
    bus.rsa = 32'h0000_0100;
    runInstr("lodRs", 32'h8812_0010, C_NONE, C_NONE, C_NONE, C_WBLOD,
             1'b1, 32'h0000_0110, 4'b0000, 1'b0, 16'd0);
    runInstr("lodImm", 32'h8012_0010, C_NONE, C_NONE, C_MEMIMM, C_WBLOD,
             1'b0, 32'd0, 4'd0, 1'b0, 16'd0);
    runInstr("op10Noop", 32'hA000_0000, C_NONE, C_NONE, C_NONE, C_NONE,
             1'b0, 32'd0, 4'd0, 1'b0, 16'd0);

    // Reset during EXECUTE aborts the instruction
    bus.rsa = 32'd5; bus.rsb = 32'd7;
    bus.ir = 32'h1031_2000;
    applyStimulus("abort.fetch", C_FETCH, 1'b0, 32'd0, 4'd0, 1'b0, 16'd0);
    applyStimulus("abort.decode", C_NONE, 1'b0, 32'd0, 4'd0, 1'b0, 16'd0);
    rst_f = 1'b0;
    applyStimulus("abort.execute", C_EXALU, 1'b1, 32'd12, 4'b0000, 1'b0, 16'd0);
    rst_f = 1'b1;
    applyStimulus("abort.start0", C_START0, 1'b0, 32'd0, 4'd0, 1'b0, 16'd0);
    applyStimulus("abort.start1", C_NONE, 1'b0, 32'd0, 4'd0, 1'b0, 16'd0);

    // HLT parks the FSM until reset
    bus.ir = 32'hF000_0000;
    applyStimulus("hlt.fetch", C_FETCH, 1'b0, 32'd0, 4'd0, 1'b0, 16'd0);
    applyStimulus("hlt.decode", C_NONE, 1'b0, 32'd0, 4'd0, 1'b0, 16'd0);
    for (int i = 0; i < 4; i++)
      applyStimulus("hlt.halted", C_NONE, 1'b0, 32'd0, 4'd0, 1'b0, 16'd0);
    rst_f = 1'b0;
    applyStimulus("hlt.rstLow", C_NONE, 1'b0, 32'd0, 4'd0, 1'b0, 16'd0);
    rst_f = 1'b1;
    applyStimulus("hlt.start0", C_START0, 1'b0, 32'd0, 4'd0, 1'b0, 16'd0);
    applyStimulus("hlt.start1", C_NONE, 1'b0, 32'd0, 4'd0, 1'b0, 16'd0);
    bus.ir = 32'h0000_0000;
    applyStimulus("hlt.refetch", C_FETCH, 1'b0, 32'd0, 4'd0, 1'b0, 16'd0);

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case the stimulus process ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
